// File: rtl/io_input_responder.sv
// Memory-mapped input responder: synchronizes and debounces 32 switches and 4 buttons,
// latches sticky button-press events (W1C) and serves combinational reads to the LSU.

module io_input_responder_lane (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    input  logic bypass,
    output logic synced,
    output logic deb,
    output logic deb_next
);
    logic       s1;
    logic [2:0] hist;
    logic [2:0] hist_nx;

    assign hist_nx = {hist[1:0], synced};

    // History keeps shifting in bypass so normal mode resumes from a valid window.
    always_comb begin
        deb_next = deb;
        if (bypass)
            deb_next = synced;
        else if (tick && hist_nx == 3'b111)
            deb_next = 1'b1;
        else if (tick && hist_nx == 3'b000)
            deb_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            synced <= 1'b0;
            hist   <= 3'b000;
            deb    <= 1'b0;
        end else begin
            s1     <= raw;
            synced <= s1;
            if (tick)
                hist <= hist_nx;
            deb    <= deb_next;
        end
    end
endmodule

module io_input_responder #(
    parameter int TICK_DIV       = 50000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic        o_btn_evt
);
    localparam int NUM_LANES = 36;
    localparam int CW        = $clog2(TICK_DIV);

    logic [CW-1:0]        tick_cnt;
    logic                 tick;
    logic [NUM_LANES-1:0] raw, synced, deb, deb_next;
    logic [3:0]           btn_edge, edge_set, edge_clr;
    logic                 bypass;
    logic                 wr;
    logic                 unused_bits;

    // Lanes 31:0 are switches, 35:32 are buttons normalised to active-high.
    assign raw  = {(BTN_ACTIVE_LOW ? ~i_io_btn : i_io_btn), i_io_sw};
    assign tick = (tick_cnt == CW'(TICK_DIV - 1));
    assign wr   = i_sel & i_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        io_input_responder_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw[g]),
            .tick     (tick),
            .bypass   (bypass),
            .synced   (synced[g]),
            .deb      (deb[g]),
            .deb_next (deb_next[g])
        );
    end

    // Rising edge is judged on the value being committed this cycle, so set and
    // a same-cycle W1C collide in one update where set wins.
    assign edge_set = ~deb[35:32] & deb_next[35:32];
    assign edge_clr = (wr && i_addr[4:2] == 3'd3) ? i_wdata[3:0] : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_edge <= 4'd0;
            bypass   <= 1'b0;
        end else begin
            btn_edge <= (btn_edge & ~edge_clr) | edge_set;
            if (wr && i_addr[4:2] == 3'd4)
                bypass <= i_wdata[0];
        end
    end

    assign o_btn_evt = |btn_edge;

    always_comb begin
        o_rdata = '0;
        if (i_sel && i_re) begin
            case (i_addr[4:2])
                3'd0:    o_rdata = synced[31:0];
                3'd1:    o_rdata = deb[31:0];
                3'd2:    o_rdata = {24'd0, synced[35:32], deb[35:32]};
                3'd3:    o_rdata = {28'd0, btn_edge};
                3'd4:    o_rdata = {31'd0, bypass};
                default: o_rdata = '0;
            endcase
        end
    end

    assign unused_bits = ^{i_addr[31:5], i_addr[1:0], i_wdata[31:4], deb_next[31:0]};
endmodule

// File: tb/tb_io_input_responder.sv
// Directed bench for io_input_responder with TICK_DIV=4 and active-low buttons.

module tb_io_input_responder;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sel = 1'b0, i_we = 1'b0, i_re = 1'b0;
    logic [31:0] i_addr = '0, i_wdata = '0, i_io_sw = '0;
    logic [3:0]  i_io_btn = 4'hF;
    logic [31:0] o_rdata;
    logic        o_btn_evt;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    io_input_responder #(.TICK_DIV(TICK_DIV), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sel     (i_sel),
        .i_we      (i_we),
        .i_re      (i_re),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .o_rdata   (o_rdata),
        .i_io_sw   (i_io_sw),
        .i_io_btn  (i_io_btn),
        .o_btn_evt (o_btn_evt)
    );

    always #10 clk = ~clk;

    // Edges since reset release; debounced values may change on edges where cyc % 4 == 0.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % TICK_DIV != 0);
    endtask

    task automatic rd(input logic [2:0] w, output logic [31:0] d);
        i_sel = 1'b1; i_re = 1'b1; i_addr = {27'd0, w, 2'b00};
        #1;
        d = o_rdata;
        i_sel = 1'b0; i_re = 1'b0; i_addr = '0;
    endtask

    task automatic wr(input logic [2:0] w, input logic [31:0] v);
        i_sel = 1'b1; i_we = 1'b1; i_addr = {27'd0, w, 2'b00}; i_wdata = v;
        @(posedge clk);
        #1;
        i_sel = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; i_io_sw = 32'hFFFF_FFFF; i_io_btn = 4'hF;
        cyc_n(3);
        for (int w = 0; w < 8; w++) begin
            rd(3'(w), d);
            nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL reset_rd%0d got %h exp %h", w, d, 32'h0); end
        end
        nvec++; if (o_btn_evt !== 1'b0) begin nerr++; $display("FAIL reset_evt got %b exp 0", o_btn_evt); end
        rst = 1'b0;
        cyc_n(1); rd(3'd0, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL sw_raw_1cyc got %h exp %h", d, 32'h0); end
        cyc_n(1); rd(3'd0, d);
        nvec++; if (d !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL sw_raw_2cyc got %h exp %h", d, 32'hFFFF_FFFF); end
        cyc_n(9); rd(3'd1, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL sw_deb_11cyc got %h exp %h", d, 32'h0); end
        cyc_n(1); rd(3'd1, d);
        nvec++; if (d !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL sw_deb_12cyc got %h exp %h", d, 32'hFFFF_FFFF); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        i_io_btn = 4'hE; cyc_n(1);
        i_io_btn = 4'hF; cyc_n(20);
        rd(3'd2, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL glitch_btn got %h exp %h", d, 32'h0); end
        rd(3'd3, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL glitch_edge got %h exp %h", d, 32'h0); end
        nvec++; if (o_btn_evt !== 1'b0) begin nerr++; $display("FAIL glitch_evt got %b exp 0", o_btn_evt); end
    endtask

    task automatic test_press();
        logic [31:0] d;
        i_io_btn = 4'hB; cyc_n(20);
        rd(3'd2, d);
        nvec++; if (d !== 32'h44) begin nerr++; $display("FAIL press_btn got %h exp %h", d, 32'h44); end
        rd(3'd3, d);
        nvec++; if (d !== 32'h4) begin nerr++; $display("FAIL press_edge got %h exp %h", d, 32'h4); end
        nvec++; if (o_btn_evt !== 1'b1) begin nerr++; $display("FAIL press_evt got %b exp 1", o_btn_evt); end
        i_io_btn = 4'hF; cyc_n(20);
        rd(3'd2, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL release_btn got %h exp %h", d, 32'h0); end
        rd(3'd3, d);
        nvec++; if (d !== 32'h4) begin nerr++; $display("FAIL release_edge got %h exp %h", d, 32'h4); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        align();
        i_io_btn = 4'hD; cyc_n(11);
        rd(3'd3, d);
        nvec++; if (d !== 32'h4) begin nerr++; $display("FAIL race_pre_edge got %h exp %h", d, 32'h4); end
        rd(3'd2, d);
        nvec++; if (d !== 32'h20) begin nerr++; $display("FAIL race_pre_btn got %h exp %h", d, 32'h20); end
        wr(3'd3, 32'h4);
        rd(3'd3, d);
        nvec++; if (d !== 32'h2) begin nerr++; $display("FAIL race_clr_other got %h exp %h", d, 32'h2); end
        rd(3'd2, d);
        nvec++; if (d !== 32'h22) begin nerr++; $display("FAIL race_btn got %h exp %h", d, 32'h22); end
        i_io_btn = 4'hF; cyc_n(16);
        rd(3'd2, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL race_release got %h exp %h", d, 32'h0); end
        align();
        i_io_btn = 4'hD; cyc_n(11);
        wr(3'd3, 32'h2);
        rd(3'd3, d);
        nvec++; if (d !== 32'h2) begin nerr++; $display("FAIL race_set_wins got %h exp %h", d, 32'h2); end
        i_io_btn = 4'hF;
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL w1c_clear got %h exp %h", d, 32'h0); end
        nvec++; if (o_btn_evt !== 1'b0) begin nerr++; $display("FAIL w1c_evt got %b exp 0", o_btn_evt); end
        cyc_n(16);
    endtask

    task automatic test_bypass();
        logic [31:0] d;
        i_sel = 1'b1; i_we = 1'b1; i_re = 1'b1; i_addr = 32'h10; i_wdata = 32'hFFFF_FFFF;
        #1;
        d = o_rdata;
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL cfg_prewrite got %h exp %h", d, 32'h0); end
        @(posedge clk); #1;
        i_sel = 1'b0; i_we = 1'b0; i_re = 1'b0; i_addr = '0; i_wdata = '0;
        rd(3'd4, d);
        nvec++; if (d !== 32'h1) begin nerr++; $display("FAIL cfg_read got %h exp %h", d, 32'h1); end
        rd(3'd6, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL unmapped_rd got %h exp %h", d, 32'h0); end
        i_sel = 1'b0; i_we = 1'b1; i_addr = 32'h10; i_wdata = 32'h0;
        cyc_n(1);
        i_we = 1'b0; i_addr = '0;
        rd(3'd4, d);
        nvec++; if (d !== 32'h1) begin nerr++; $display("FAIL nosel_write got %h exp %h", d, 32'h1); end
        wr(3'd0, 32'h0);
        i_io_sw = 32'h0000_00A5; cyc_n(2);
        rd(3'd1, d);
        nvec++; if (d !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL bypass_2cyc got %h exp %h", d, 32'hFFFF_FFFF); end
        cyc_n(1);
        rd(3'd1, d);
        nvec++; if (d !== 32'hA5) begin nerr++; $display("FAIL bypass_3cyc got %h exp %h", d, 32'hA5); end
        rd(3'd0, d);
        nvec++; if (d !== 32'hA5) begin nerr++; $display("FAIL ro_write got %h exp %h", d, 32'hA5); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(3'd4, 32'h0);
        i_io_btn = 4'h7; cyc_n(20);
        rd(3'd3, d);
        nvec++; if (d !== 32'h8) begin nerr++; $display("FAIL mid_pre_edge got %h exp %h", d, 32'h8); end
        nvec++; if (o_btn_evt !== 1'b1) begin nerr++; $display("FAIL mid_pre_evt got %b exp 1", o_btn_evt); end
        #3 rst = 1'b1;
        #1;
        for (int w = 0; w < 8; w++) begin
            rd(3'(w), d);
            nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL mid_rst_rd%0d got %h exp %h", w, d, 32'h0); end
        end
        nvec++; if (o_btn_evt !== 1'b0) begin nerr++; $display("FAIL mid_rst_evt got %b exp 0", o_btn_evt); end
        i_io_btn = 4'hF; cyc_n(2);
        rst = 1'b0;
        cyc_n(11);
        rd(3'd1, d);
        nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL mid_deb_11cyc got %h exp %h", d, 32'h0); end
        rd(3'd0, d);
        nvec++; if (d !== 32'hA5) begin nerr++; $display("FAIL mid_raw got %h exp %h", d, 32'hA5); end
        cyc_n(1);
        rd(3'd1, d);
        nvec++; if (d !== 32'hA5) begin nerr++; $display("FAIL mid_deb_12cyc got %h exp %h", d, 32'hA5); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_w1c_race();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d vectors", nvec);
        $fatal(1);
    end
endmodule
